// File: rtl/arb_pkg.sv
// Shared definitions for the SRAM-like port arbiter: owner encoding of the
// two masters sharing the memory port.
package arb_pkg;

    typedef logic owner_t;

    localparam owner_t OWN_INST = 1'b0;
    localparam owner_t OWN_DATA = 1'b1;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like bus: request fields flow master->slave, acknowledges and
// read data flow slave->master.
interface sram_like_arbiter_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/arb_order_fifo.sv
// Small in-order FIFO recording which master owns each accepted request.
// Pointers wrap naturally because DEPTH is a power of two.
module arb_order_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = slots[rd_ptr];

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push_ok) slots[wr_ptr] <= push_data;
    end

    // Pointer and occupancy tracking; push+pop together leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between the inst and data masters.
// Data wins by default; inst is forced through once after STARVE_LIMIT data
// grants while it waits. An unaccepted request locks the grant so the mem
// fields stay stable, and an order FIFO steers responses back to their owner.
module sram_like_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_like_arbiter_if.slave   inst,
    sram_like_arbiter_if.slave   data,
    sram_like_arbiter_if.master  mem,
    output logic                 proto_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic          locked, locked_nxt;
    owner_t        lock_owner, lock_owner_nxt;
    logic [SW-1:0] starve_cnt;

    logic          gnt_vld;
    owner_t        gnt_own;
    logic          mem_req_int;
    logic          hs;
    logic          pop;

    owner_t        fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    // Lock state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked     <= 1'b0;
            lock_owner <= OWN_INST;
        end else begin
            locked     <= locked_nxt;
            lock_owner <= lock_owner_nxt;
        end
    end

    // Lock next state: hold the grantee while its request waits for addr_ok.
    always_comb begin
        locked_nxt     = locked;
        lock_owner_nxt = lock_owner;
        if (hs) begin
            locked_nxt = 1'b0;
        end else if (mem_req_int) begin
            locked_nxt     = 1'b1;
            lock_owner_nxt = gnt_own;
        end
    end

    // Grant selection from requests and registered state only.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_own = OWN_DATA;
        if (!fifo_full) begin
            if (locked) begin
                gnt_vld = 1'b1;
                gnt_own = lock_owner;
            end else if (data.req) begin
                gnt_vld = 1'b1;
                gnt_own = (inst.req && starve_cnt == STARVE_MAX) ? OWN_INST : OWN_DATA;
            end else if (inst.req) begin
                gnt_vld = 1'b1;
                gnt_own = OWN_INST;
            end
        end
    end

    assign mem_req_int = ~reset & gnt_vld & ((gnt_own == OWN_INST) ? inst.req : data.req);
    assign hs          = mem_req_int & mem.addr_ok;
    assign pop         = ~reset & mem.data_ok & (fifo_count != '0);

    // Output mux: forward the grantee's fields and steer acknowledges.
    always_comb begin
        mem.req   = mem_req_int;
        mem.wr    = (gnt_own == OWN_INST) ? inst.wr    : data.wr;
        mem.size  = (gnt_own == OWN_INST) ? inst.size  : data.size;
        mem.wstrb = (gnt_own == OWN_INST) ? inst.wstrb : data.wstrb;
        mem.addr  = (gnt_own == OWN_INST) ? inst.addr  : data.addr;
        mem.wdata = (gnt_own == OWN_INST) ? inst.wdata : data.wdata;

        inst.addr_ok = hs & (gnt_own == OWN_INST);
        data.addr_ok = hs & (gnt_own == OWN_DATA);
        inst.data_ok = pop & (fifo_head == OWN_INST);
        data.data_ok = pop & (fifo_head == OWN_DATA);
        inst.rdata   = mem.rdata;
        data.rdata   = mem.rdata;
    end

    // Count data grants that jump a waiting inst request; saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!inst.req) begin
            starve_cnt <= '0;
        end else if (hs && gnt_own == OWN_INST) begin
            starve_cnt <= '0;
        end else if (hs && gnt_own == OWN_DATA && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (mem.data_ok && fifo_empty) begin
            proto_err <= 1'b1;
        end
    end

    arb_order_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_order_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (hs),
        .push_data (gnt_own),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
